sram_port_arbiter: RTL and testbench

- Shares the single byte-addressed 32-bit SRAM between two requesters: the instruction-fetch port (I, read-only) and the MEM-stage data port (D, read/write).
- Each cycle it grants at most one requester and drives the SRAM address, write-enable and write data.
- It registers the read data and returns it one cycle after the grant.
- It enforces fairness and rejects illegal byte-write masks.
- It sits between the pipeline IF/MEM stages and the SRAM instance.

---
 rtl/sram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one byte-addressed SRAM between the instruction-fetch port (I, read-only)
// and the MEM-stage data port (D, read/write); read data returns one cycle after grant.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned RR_MODE      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_err,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_w_en,
  output logic [DATA_W-1:0]   sram_write_data,
  input  logic [DATA_W-1:0]   sram_read_data
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  grant_e              last_grant_q;
  logic [STREAK_W-1:0] streak_q;
  logic                grant_i;
  logic                grant_d;
  logic                d_is_read;
  logic                d_mask_ok;

  // Legal store masks fill the word from byte 0 upward (0001, 0011, 0111, 1111).
  assign d_is_read = (d_wen == '0);
  assign d_mask_ok = !d_is_read && ((d_wen & (d_wen + BE_W'(1))) == '0);

  // Grant decision; everything is gated off while reset is asserted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
        if (RR_MODE != 0) begin
          grant_i = (last_grant_q == GNT_D);
        end else begin
          grant_i = (streak_q == STREAK_MAX);
        end
        grant_d = !grant_i;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign i_ack = grant_i;
  assign d_ack = grant_d;

  // SRAM drive: winner's address, write only for a legal D mask.
  always_comb begin
    sram_address    = '0;
    sram_w_en       = '0;
    sram_write_data = '0;
    if (grant_i) begin
      sram_address = i_addr;
    end else if (grant_d) begin
      sram_address    = d_addr;
      sram_write_data = d_wdata;
      if (d_mask_ok) begin
        sram_w_en = d_wen;
      end
    end
  end

  // Read return, error pulse and fairness state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata      <= '0;
      i_rvalid     <= 1'b0;
      d_rdata      <= '0;
      d_rvalid     <= 1'b0;
      d_err        <= 1'b0;
      streak_q     <= '0;
      last_grant_q <= GNT_I;
    end else begin
      i_rvalid <= grant_i;
      d_rvalid <= grant_d && d_is_read;
      d_err    <= grant_d && !d_is_read && !d_mask_ok;

      if (grant_i) begin
        i_rdata <= sram_read_data;
      end
      if (grant_d && d_is_read) begin
        d_rdata <= sram_read_data;
      end

      if (grant_i) begin
        last_grant_q <= GNT_I;
      end else if (grant_d) begin
        last_grant_q <= GNT_D;
      end

      // The streak only counts D wins that kept a waiting fetch out.
      if (i_req && grant_d) begin
        if (streak_q != STREAK_MAX) begin
          streak_q <= streak_q + STREAK_W'(1);
        end
      end else begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (D-priority and round-robin) on shared
// stimulus, each with its own SRAM, checked against a transaction-level reference.
module tb_sram_port_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned MAXS = 4;
  localparam int unsigned NPRE = 5;
  localparam int unsigned NV   = 17;

  localparam logic [AW-1:0] PRE_A [NPRE] = '{16'h0010, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
  localparam logic [DW-1:0] PRE_D [NPRE] = '{32'hDEADBEEF, 32'hAABBCCDD, 32'h11223344,
                                            32'h55667788, 32'h99AABBCC};

  typedef struct {
    logic          iack;
    logic          dack;
    logic [AW-1:0] addr;
    logic [BW-1:0] wen;
    logic          irv;
    logic          drv;
    logic          err;
    logic [DW-1:0] irdata;
    logic [DW-1:0] drdata;
  } obs_t;

  typedef struct {
    logic          ireq;
    logic [AW-1:0] ia;
    logic          dreq;
    logic [AW-1:0] da;
    logic [BW-1:0] wen;
    logic [DW-1:0] wd;
    logic          e_iack;
    logic          e_dack;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_wen;
    logic          e_irv;
    logic          e_drv;
    logic          e_err;
    logic [DW-1:0] e_rdata;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic          d_req;
  logic [AW-1:0] i_addr;
  logic [AW-1:0] d_addr;
  logic [BW-1:0] d_wen;
  logic [DW-1:0] d_wdata;

  logic [1:0]         i_ack, d_ack, i_rvalid, d_rvalid, d_err;
  logic [1:0][DW-1:0] i_rdata, d_rdata, s_wd, s_rd;
  logic [1:0][AW-1:0] s_a;
  logic [1:0][BW-1:0] s_we;

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_D_STREAK(4), .RR_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]), .i_rvalid(i_rvalid[0]),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_rvalid(d_rvalid[0]), .d_err(d_err[0]),
    .sram_address(s_a[0]), .sram_w_en(s_we[0]), .sram_write_data(s_wd[0]),
    .sram_read_data(s_rd[0])
  );

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_D_STREAK(4), .RR_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]), .i_rvalid(i_rvalid[1]),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_rvalid(d_rvalid[1]), .d_err(d_err[1]),
    .sram_address(s_a[1]), .sram_w_en(s_we[1]), .sram_write_data(s_wd[1]),
    .sram_read_data(s_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: little-endian bytes, combinational read, write on rising edge.
  logic [7:0] sram_mem [2][65536];
  bit         preloaded;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 65536; i++) sram_mem[k][i] <= 8'h00;
        for (int p = 0; p < int'(NPRE); p++)
          for (int b = 0; b < 4; b++)
            sram_mem[k][16'(PRE_A[p] + 16'(b))] <= PRE_D[p][8*b +: 8];
      end
      preloaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 4; b++)
          if (s_we[k][b]) sram_mem[k][16'(s_a[k] + 16'(b))] <= s_wd[k][8*b +: 8];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      s_rd[k] = {sram_mem[k][16'(s_a[k] + 16'd3)], sram_mem[k][16'(s_a[k] + 16'd2)],
                 sram_mem[k][16'(s_a[k] + 16'd1)], sram_mem[k][s_a[k]]};
  end

  // Reference state per instance.
  logic [7:0]    ref_mem [2][65536];
  int unsigned   m_streak [2];
  bit            m_last   [2];
  bit            m_irv    [2];
  bit            m_drv    [2];
  bit            m_err    [2];
  logic [DW-1:0] m_irdata [2];
  logic [DW-1:0] m_drdata [2];
  obs_t          obs      [2];
  vec_t          vt       [NV];
  int            n_checks;
  int            n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mask_legal(input logic [BW-1:0] w);
    return (w == 4'b0001) || (w == 4'b0011) || (w == 4'b0111) || (w == 4'b1111);
  endfunction

  function automatic logic [DW-1:0] ref_word(input int k, input logic [AW-1:0] a);
    return {ref_mem[k][16'(a + 16'd3)], ref_mem[k][16'(a + 16'd2)],
            ref_mem[k][16'(a + 16'd1)], ref_mem[k][a]};
  endfunction

  // Instance 0 favours D until MAXS wins in a row; instance 1 alternates.
  function automatic void predict(input int k, output bit gi, output bit gd);
    gi = 1'b0;
    gd = 1'b0;
    if (i_req && !d_req) gi = 1'b1;
    else if (d_req && !i_req) gd = 1'b1;
    else if (i_req && d_req) begin
      if (k == 1) gi = m_last[k];
      else        gi = (m_streak[k] == MAXS);
      gd = !gi;
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_streak[k] = 0;
      m_last[k]   = 1'b0;
      m_irv[k]    = 1'b0;
      m_drv[k]    = 1'b0;
      m_err[k]    = 1'b0;
      m_irdata[k] = '0;
      m_drdata[k] = '0;
    end
  endtask

  task automatic init_ref();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 65536; i++) ref_mem[k][i] = 8'h00;
      for (int p = 0; p < int'(NPRE); p++)
        for (int b = 0; b < 4; b++) ref_mem[k][16'(PRE_A[p] + 16'(b))] = PRE_D[p][8*b +: 8];
    end
  endtask

  // One clock with inputs already driven: combinational checks, edge, registered checks.
  task automatic step();
    bit gi [2];
    bit gd [2];
    logic [AW-1:0] ea;
    #1;
    for (int k = 0; k < 2; k++) begin
      predict(k, gi[k], gd[k]);
      obs[k].iack = i_ack[k];
      obs[k].dack = d_ack[k];
      obs[k].addr = s_a[k];
      obs[k].wen  = s_we[k];
      ea = gi[k] ? i_addr : (gd[k] ? d_addr : '0);
      chk($sformatf("u%0d.i_ack", k), 32'(i_ack[k]), 32'(gi[k]));
      chk($sformatf("u%0d.d_ack", k), 32'(d_ack[k]), 32'(gd[k]));
      chk($sformatf("u%0d.sram_address", k), 32'(s_a[k]), 32'(ea));
      chk($sformatf("u%0d.sram_w_en", k), 32'(s_we[k]),
          32'((gd[k] && mask_legal(d_wen)) ? d_wen : 4'h0));
      chk($sformatf("u%0d.sram_write_data", k), s_wd[k], gd[k] ? d_wdata : 32'h0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_irv[k] = gi[k];
      if (gi[k]) m_irdata[k] = ref_word(k, i_addr);
      m_drv[k] = gd[k] && (d_wen == 4'h0);
      if (m_drv[k]) m_drdata[k] = ref_word(k, d_addr);
      m_err[k] = gd[k] && (d_wen != 4'h0) && !mask_legal(d_wen);
      if (gd[k] && mask_legal(d_wen))
        for (int b = 0; b < 4; b++)
          if (d_wen[b]) ref_mem[k][16'(d_addr + 16'(b))] = d_wdata[8*b +: 8];
      if (gi[k]) m_last[k] = 1'b0;
      else if (gd[k]) m_last[k] = 1'b1;
      if (i_req && gd[k]) m_streak[k] = (m_streak[k] < MAXS) ? m_streak[k] + 1 : MAXS;
      else m_streak[k] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      obs[k].irv    = i_rvalid[k];
      obs[k].drv    = d_rvalid[k];
      obs[k].err    = d_err[k];
      obs[k].irdata = i_rdata[k];
      obs[k].drdata = d_rdata[k];
      chk($sformatf("u%0d.i_rvalid", k), 32'(i_rvalid[k]), 32'(m_irv[k]));
      chk($sformatf("u%0d.d_rvalid", k), 32'(d_rvalid[k]), 32'(m_drv[k]));
      chk($sformatf("u%0d.d_err", k), 32'(d_err[k]), 32'(m_err[k]));
      chk($sformatf("u%0d.i_rdata", k), i_rdata[k], m_irdata[k]);
      if (m_drv[k]) chk($sformatf("u%0d.d_rdata", k), d_rdata[k], m_drdata[k]);
    end
    @(negedge clk);
  endtask

  // Reset with both requests high so ack gating is exercised.
  task automatic apply_reset();
    rst_n   = 1'b0;
    i_req   = 1'b1;
    d_req   = 1'b1;
    i_addr  = 16'h0010;
    d_addr  = 16'h0100;
    d_wen   = 4'hF;
    d_wdata = 32'hFFFFFFFF;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst.u%0d.i_ack", k), 32'(i_ack[k]), 32'h0);
      chk($sformatf("rst.u%0d.d_ack", k), 32'(d_ack[k]), 32'h0);
      chk($sformatf("rst.u%0d.sram_w_en", k), 32'(s_we[k]), 32'h0);
      chk($sformatf("rst.u%0d.i_rvalid", k), 32'(i_rvalid[k]), 32'h0);
      chk($sformatf("rst.u%0d.d_rvalid", k), 32'(d_rvalid[k]), 32'h0);
      chk($sformatf("rst.u%0d.d_err", k), 32'(d_err[k]), 32'h0);
      chk($sformatf("rst.u%0d.i_rdata", k), i_rdata[k], 32'h0);
      chk($sformatf("rst.u%0d.d_rdata", k), d_rdata[k], 32'h0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(3))
      0:       return PRE_A[$urandom_range(NPRE - 1)];
      1:       return 16'hFFFC + 16'($urandom_range(3));
      2:       return 16'($urandom_range(15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [9:0] pat0;
    logic [9:0] pat1;
    logic [4:0] pat2;
    bit   [1:0] iseen;
    bit   [1:0] dseen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    init_ref();
    apply_reset();

    // Directed single-requester vectors.
    vt[0]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 16'h0010, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 4'h3, 32'h12345678, 1'b0, 1'b1, 16'h0100, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 4'h0, 32'h0,        1'b0, 1'b1, 16'h0100, 4'h0, 1'b0, 1'b1, 1'b0, 32'hAABB5678};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0200, 4'h5, 32'hFFFFFFFF, 1'b0, 1'b1, 16'h0200, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0200, 4'h0, 32'h0,        1'b0, 1'b1, 16'h0200, 4'h0, 1'b0, 1'b1, 1'b0, 32'h11223344};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 4'hF, 32'h01020304, 1'b0, 1'b1, 16'hFFFE, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 4'h0, 32'h0,        1'b0, 1'b1, 16'hFFFE, 4'h0, 1'b0, 1'b1, 1'b0, 32'h01020304};
    vt[7]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h00000102};
    vt[8]  = '{1'b0, 16'h1234, 1'b0, 16'h5678, 4'h0, 32'h0,        1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 4'h8, 32'hFFFFFFFF, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b1, 16'h0010, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 16'h0010, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 4'h7, 32'hCAFEBABE, 1'b0, 1'b1, 16'h0100, 4'h7, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[12] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 4'h0, 32'h0,        1'b0, 1'b1, 16'h0100, 4'h0, 1'b0, 1'b1, 1'b0, 32'hAAFEBABE};
    vt[13] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 4'h1, 32'h000000EE, 1'b0, 1'b1, 16'h0300, 4'h1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[14] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 4'hE, 32'h0,        1'b0, 1'b1, 16'h0300, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[15] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 4'h2, 32'h0,        1'b0, 1'b1, 16'h0300, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[16] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 4'h0, 32'h0,        1'b0, 1'b1, 16'h0300, 4'h0, 1'b0, 1'b1, 1'b0, 32'h556677EE};

    for (int v = 0; v < int'(NV); v++) begin
      i_req   = vt[v].ireq;
      i_addr  = vt[v].ia;
      d_req   = vt[v].dreq;
      d_addr  = vt[v].da;
      d_wen   = vt[v].wen;
      d_wdata = vt[v].wd;
      step();
      chk($sformatf("v%0d.i_ack", v), 32'(obs[0].iack), 32'(vt[v].e_iack));
      chk($sformatf("v%0d.d_ack", v), 32'(obs[0].dack), 32'(vt[v].e_dack));
      chk($sformatf("v%0d.addr", v), 32'(obs[0].addr), 32'(vt[v].e_addr));
      chk($sformatf("v%0d.w_en", v), 32'(obs[0].wen), 32'(vt[v].e_wen));
      chk($sformatf("v%0d.i_rvalid", v), 32'(obs[0].irv), 32'(vt[v].e_irv));
      chk($sformatf("v%0d.d_rvalid", v), 32'(obs[0].drv), 32'(vt[v].e_drv));
      chk($sformatf("v%0d.d_err", v), 32'(obs[0].err), 32'(vt[v].e_err));
      if (vt[v].e_irv) chk($sformatf("v%0d.i_rdata", v), obs[0].irdata, vt[v].e_rdata);
      else if (vt[v].e_drv) chk($sformatf("v%0d.d_rdata", v), obs[0].drdata, vt[v].e_rdata);
    end

    // Continuous contention: D-priority with guard vs. round-robin.
    apply_reset();
    pat0    = 10'b1111011110;
    pat1    = 10'b1010101010;
    i_req   = 1'b1;
    d_req   = 1'b1;
    i_addr  = 16'h0010;
    d_addr  = 16'h0200;
    d_wen   = 4'h0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("cont.u0.d_ack[%0d]", c), 32'(obs[0].dack), 32'(pat0[9-c]));
      chk($sformatf("cont.u1.d_ack[%0d]", c), 32'(obs[1].dack), 32'(pat1[9-c]));
    end

    // Reset dropped in the middle of a granted D write.
    apply_reset();
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_wen  = 4'h0;
    d_addr = 16'h0200;
    repeat (3) step();
    d_addr  = 16'h0400;
    d_wen   = 4'hF;
    d_wdata = 32'hCAFEF00D;
    #1;
    chk("midrst.pre_d_ack", 32'(d_ack[0]), 32'h1);
    chk("midrst.pre_w_en", 32'(s_we[0]), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst.u%0d.d_ack", k), 32'(d_ack[k]), 32'h0);
      chk($sformatf("midrst.u%0d.i_ack", k), 32'(i_ack[k]), 32'h0);
      chk($sformatf("midrst.u%0d.w_en", k), 32'(s_we[k]), 32'h0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst.u%0d.d_rvalid", k), 32'(d_rvalid[k]), 32'h0);
      chk($sformatf("midrst.u%0d.d_err", k), 32'(d_err[k]), 32'h0);
      chk($sformatf("midrst.u%0d.i_rvalid", k), 32'(i_rvalid[k]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_wen = 4'h0;
    pat2  = 5'b11110;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("midrst.streak.d_ack[%0d]", c), 32'(obs[0].dack), 32'(pat2[4-c]));
    end
    i_req = 1'b0;
    step();
    chk("midrst.readback.d_rvalid", 32'(obs[0].drv), 32'h1);
    chk("midrst.readback.d_rdata", obs[0].drdata, 32'h99AABBCC);

    // Randomized traffic; request fields held until both instances have acked.
    apply_reset();
    iseen = '0;
    dseen = '0;
    for (int c = 0; c < 600; c++) begin
      if (!i_req || (iseen == 2'b11)) begin
        i_req  = ($urandom_range(3) != 0);
        i_addr = pick_addr();
        iseen  = '0;
      end
      if (!d_req || (dseen == 2'b11)) begin
        d_req   = ($urandom_range(3) != 0);
        d_addr  = pick_addr();
        d_wen   = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        d_wdata = $urandom;
        dseen   = '0;
      end
      step();
      for (int k = 0; k < 2; k++) begin
        if (obs[k].iack) iseen[k] = 1'b1;
        if (obs[k].dack) dseen[k] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
